// File: rtl/addr_decoder_if.sv
// Request/result bundle for the frame-buffer address decoder.
interface addr_decoder_if #(
  parameter int PIXELBITS = 6
);
  logic                 start;
  logic [31:0]          address;
  logic [31:0]          offset;
  logic [PIXELBITS-1:0] pixel_size;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic [9:0]           x;
  logic [9:0]           y;

  modport master (
    output start, address, offset, pixel_size,
    input  busy, done, err, x, y
  );

  modport slave (
    input  start, address, offset, pixel_size,
    output busy, done, err, x, y
  );
endinterface

// File: rtl/addr_decoder.sv
// Inverts address = offset + (y*WIDTH + x) * (pixel_size/8) into (x, y).
// Flow: IDLE -> CHECK -> DIVIDE (32 cycles) -> DONE -> IDLE, or CHECK -> DONE on error.
module addr_decoder #(
  parameter int PIXELBITS = 6,
  parameter int WIDTH     = 640,
  parameter int HEIGHT    = 480
) (
  input logic          clk,
  input logic          rst,
  addr_decoder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CHECK, DIVIDE, DONE} state_t;

  state_t               state_q, state_d;
  logic [31:0]          addr_q, addr_d;
  logic [31:0]          off_q, off_d;
  logic [PIXELBITS-1:0] psize_q, psize_d;
  logic                 chk_err_q, chk_err_d;
  logic [31:0]          quo_q, quo_d;
  logic [31:0]          rem_q, rem_d;
  logic [4:0]           cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [9:0]           x_q, x_d;
  logic [9:0]           y_q, y_d;

  logic [31:0] byte_off;
  logic [1:0]  shamt;
  logic        bad_psize;
  logic        misaligned;
  logic [32:0] trial;
  logic        trial_ge;
  logic        fin_err;

  // State, latched request, divider and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      off_q     <= '0;
      psize_q   <= '0;
      chk_err_q <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      off_q     <= off_d;
      psize_q   <= psize_d;
      chk_err_q <= chk_err_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      x_q       <= x_d;
      y_q       <= y_d;
    end
  end

  // Next-state, validity check, one restoring-division step per cycle, result update.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    off_d      = off_q;
    psize_d    = psize_q;
    chk_err_d  = chk_err_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    err_d      = err_q;
    x_d        = x_q;
    y_d        = y_q;
    byte_off   = addr_q - off_q;
    shamt      = 2'd0;
    bad_psize  = 1'b0;
    misaligned = 1'b0;
    trial      = {rem_q, quo_q[31]};
    trial_ge   = (trial >= 33'(WIDTH));
    fin_err    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          addr_d  = bus.address;
          off_d   = bus.offset;
          psize_d = bus.pixel_size;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (psize_q == PIXELBITS'(8)) begin
          shamt = 2'd0;
        end else if (psize_q == PIXELBITS'(16)) begin
          shamt      = 2'd1;
          misaligned = byte_off[0];
        end else if (psize_q == PIXELBITS'(32)) begin
          shamt      = 2'd2;
          misaligned = |byte_off[1:0];
        end else begin
          bad_psize = 1'b1;
        end
        chk_err_d = (addr_q < off_q) | bad_psize | misaligned;
        // Dividend shifts out of quo_q MSB-first while quotient bits shift in at the LSB.
        quo_d   = byte_off >> shamt;
        rem_d   = '0;
        cnt_d   = '0;
        state_d = chk_err_d ? DONE : DIVIDE;
      end
      DIVIDE: begin
        rem_d = trial_ge ? (trial[31:0] - 32'(WIDTH)) : trial[31:0];
        quo_d = {quo_q[30:0], trial_ge};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = DONE;
        end
      end
      DONE: begin
        fin_err = chk_err_q | (quo_q >= 32'(HEIGHT));
        done_d  = 1'b1;
        err_d   = fin_err;
        x_d     = fin_err ? '0 : rem_q[9:0];
        y_d     = fin_err ? '0 : quo_q[9:0];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.err  = err_q;
  assign bus.x    = x_q;
  assign bus.y    = y_q;

endmodule

// File: tb/tb_addr_decoder.sv
// Directed self-checking bench for addr_decoder (WIDTH=640, HEIGHT=480).
module tb_addr_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  addr_decoder_if #(.PIXELBITS(6)) bus ();

  addr_decoder #(.PIXELBITS(6), .WIDTH(640), .HEIGHT(480)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // One request: start sampled at edge N, then inputs scrambled; done must appear after edge N+lat.
  task automatic do_req(input logic [31:0] a, input logic [31:0] o, input logic [5:0] ps,
                        input int lat, input logic [9:0] ex, input logic [9:0] ey,
                        input logic ee, input string name);
    int cyc;
    @(negedge clk);
    bus.address = a; bus.offset = o; bus.pixel_size = ps; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.address = $urandom; bus.offset = $urandom; bus.pixel_size = 6'(8);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL %s busy: got %b want 1", name, bus.busy);
    end
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (cyc !== lat) begin
      errors++; $display("FAIL %s latency: got %0d want %0d", name, cyc, lat);
    end
    checks++;
    if (bus.x !== ex || bus.y !== ey || bus.err !== ee) begin
      errors++;
      $display("FAIL %s result: got x=%0d y=%0d err=%b want x=%0d y=%0d err=%b",
               name, bus.x, bus.y, bus.err, ex, ey, ee);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b0 || bus.x !== ex || bus.y !== ey || bus.err !== ee) begin
      errors++;
      $display("FAIL %s hold: got done=%b x=%0d y=%0d err=%b want done=0 x=%0d y=%0d err=%b",
               name, bus.done, bus.x, bus.y, bus.err, ex, ey, ee);
    end
  endtask

  task automatic test_reset;
    bus.start = 1'b0; bus.address = '0; bus.offset = '0; bus.pixel_size = 6'(8);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0 || bus.x !== 10'd0 || bus.y !== 10'd0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b err=%b x=%0d y=%0d want all 0",
               bus.busy, bus.done, bus.err, bus.x, bus.y);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_valid;
    do_req(32'd1000,   32'd1000, 6'd8,  34, 10'd0,   10'd0,   1'b0, "origin_8bpp");
    do_req(32'd1642,   32'd1000, 6'd8,  34, 10'd2,   10'd1,   1'b0, "x2y1_8bpp");
    do_req(32'd2282,   32'd1000, 6'd16, 34, 10'd1,   10'd1,   1'b0, "x1y1_16bpp");
    do_req(32'd5140,   32'd0,    6'd32, 34, 10'd5,   10'd2,   1'b0, "x5y2_32bpp");
    do_req(32'd307199, 32'd0,    6'd8,  34, 10'd639, 10'd479, 1'b0, "last_pixel");
  endtask

  task automatic test_errors;
    do_req(32'd1001,   32'd1000, 6'd16, 2,  10'd0, 10'd0, 1'b1, "misaligned16");
    do_req(32'd1002,   32'd1000, 6'd32, 2,  10'd0, 10'd0, 1'b1, "misaligned32");
    do_req(32'd999,    32'd1000, 6'd8,  2,  10'd0, 10'd0, 1'b1, "below_offset");
    do_req(32'd1000,   32'd1000, 6'd12, 2,  10'd0, 10'd0, 1'b1, "bad_psize");
    do_req(32'd308200, 32'd1000, 6'd8,  34, 10'd0, 10'd0, 1'b1, "row_480");
  endtask

  task automatic test_busy_ignore;
    int dones;
    @(negedge clk);
    bus.address = 32'd1642; bus.offset = 32'd1000; bus.pixel_size = 6'd8; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    bus.address = 32'd2282; bus.pixel_size = 6'd16; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    dones = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    checks++;
    if (dones !== 1) begin
      errors++; $display("FAIL busy_ignore_count: got %0d dones want 1", dones);
    end
    checks++;
    if (bus.x !== 10'd2 || bus.y !== 10'd1 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL busy_ignore_result: got x=%0d y=%0d err=%b want x=2 y=1 err=0", bus.x, bus.y, bus.err);
    end
  endtask

  task automatic test_reset_mid;
    int dones;
    // Previous result x=2,y=1 is still held, so clearing is observable.
    @(negedge clk);
    bus.address = 32'd2282; bus.offset = 32'd1000; bus.pixel_size = 6'd16; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0 || bus.x !== 10'd0 || bus.y !== 10'd0) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b done=%b err=%b x=%0d y=%0d want all 0",
               bus.busy, bus.done, bus.err, bus.x, bus.y);
    end
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++; $display("FAIL reset_mid_no_done: got %0d dones want 0", dones);
    end
    do_req(32'd1642, 32'd1000, 6'd8, 34, 10'd2, 10'd1, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back;
    int cyc;
    @(negedge clk);
    bus.address = 32'd2282; bus.offset = 32'd1000; bus.pixel_size = 6'd16; bus.start = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (cyc !== 34) begin
      errors++; $display("FAIL b2b_first: got %0d want 34", cyc);
    end
    cyc = 0;
    @(posedge clk); #1; cyc++;
    while (bus.done !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    bus.start = 1'b0;
    checks++;
    if (cyc !== 35) begin
      errors++; $display("FAIL b2b_gap: got %0d want 35", cyc);
    end
    checks++;
    if (bus.x !== 10'd1 || bus.y !== 10'd1 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_result: got x=%0d y=%0d err=%b want x=1 y=1 err=0", bus.x, bus.y, bus.err);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL b2b_idle: got busy=%b want 0", bus.busy);
    end
  endtask

  initial begin
    test_reset();
    test_valid();
    test_errors();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
